// File: rtl/rr_arbiter8x16.sv
// Round-robin arbiter: eight WIDTH-bit requesters share one registered output with valid/ready.
// Define RR_ARB_BURST_LOCK_EN to add the lock input for burst ownership of the channel.
module rr_arbiter8x16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       req,
`ifdef RR_ARB_BURST_LOCK_EN
  input  logic [7:0]       lock,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  output logic [7:0]       gnt,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       sel,
  output logic [CNT_W-1:0] xfer_count
);

  // state | meaning
  // EMPTY | y holds no word for the sink
  // FULL  | y holds a word waiting for out_ready
  typedef enum logic {EMPTY, FULL} ostate_t;

  ostate_t          state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       winner, idx;
  logic             found, load, hs;
  logic [7:0]       eff_req;
  logic [WIDTH-1:0] din [8];

  assign din[0] = a;
  assign din[1] = b;
  assign din[2] = c;
  assign din[3] = d;
  assign din[4] = e;
  assign din[5] = f;
  assign din[6] = g;
  assign din[7] = h;

`ifdef RR_ARB_BURST_LOCK_EN
  logic       locked_q, locked_d;
  logic [2:0] owner_q, owner_d;
  // While locked only the owner competes; everyone else waits.
  assign eff_req = locked_q ? (req & (8'd1 << owner_q)) : req;
`else
  assign eff_req = req;
`endif

  assign out_valid = (state_q == FULL);
  assign hs        = out_valid & out_ready;
  assign load      = (!out_valid | out_ready) & (|eff_req);
  assign gnt       = (load && !reset) ? (8'd1 << winner) : 8'd0;

  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && eff_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
`ifdef RR_ARB_BURST_LOCK_EN
    locked_d = locked_q;
    owner_d  = owner_q;
`endif
    if (load) begin
      state_d = FULL;
`ifdef RR_ARB_BURST_LOCK_EN
      if (lock[winner]) begin
        locked_d = 1'b1;
        owner_d  = winner;
      end else begin
        locked_d = 1'b0;
        ptr_d    = winner + 3'd1;
      end
`else
      ptr_d = winner + 3'd1;
`endif
    end else begin
      if (hs) state_d = EMPTY;
`ifdef RR_ARB_BURST_LOCK_EN
      // Owner dropped its request: release the channel and move past it.
      if (locked_q && !req[owner_q]) begin
        locked_d = 1'b0;
        ptr_d    = owner_q + 3'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      y          <= '0;
      sel        <= '0;
      xfer_count <= '0;
`ifdef RR_ARB_BURST_LOCK_EN
      locked_q   <= 1'b0;
      owner_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
`ifdef RR_ARB_BURST_LOCK_EN
      locked_q <= locked_d;
      owner_q  <= owner_d;
`endif
      if (load) begin
        y   <= din[winner];
        sel <= winner;
      end
      if (hs) xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rr_arbiter8x16.sv
// Self-checking bench for rr_arbiter8x16: directed scenarios plus randomized requesters
// checked cycle by cycle against a behavioural round-robin model.
module tb_rr_arbiter8x16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        out_ready = 1'b0;
  logic [7:0]  req = 8'h00;
  logic [7:0]  lk = 8'h00;
  logic [15:0] dat [8];
  logic [7:0]  gnt;
  logic [15:0] y;
  logic        out_valid;
  logic [2:0]  sel;
  logic [15:0] xfer_count;

  int checks = 0;
  int errors = 0;

  int          m_ptr, m_sel, m_cnt, m_owner;
  bit          m_valid, m_locked;
  logic [15:0] m_y;

  always #5 clk = ~clk;

  rr_arbiter8x16 dut (
    .clk(clk), .reset(reset), .req(req),
`ifdef RR_ARB_BURST_LOCK_EN
    .lock(lk),
`endif
    .a(dat[0]), .b(dat[1]), .c(dat[2]), .d(dat[3]),
    .e(dat[4]), .f(dat[5]), .g(dat[6]), .h(dat[7]),
    .gnt(gnt), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .sel(sel), .xfer_count(xfer_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First requester found scanning from the priority pointer, or the lock owner alone.
  function automatic int pick();
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < 8; k++)
      if (req[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_sel = 0; m_cnt = 0; m_owner = 0;
    m_valid = 0; m_locked = 0; m_y = 16'h0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_y"}, y, m_y);
    chk({tag, "_sel"}, sel, m_sel);
    chk({tag, "_valid"}, out_valid, m_valid);
    chk({tag, "_cnt"}, xfer_count, m_cnt);
  endtask

  // One clock: check Mealy grant mid-cycle, advance the model at the edge, check registers.
  task automatic step(input string tag, output int w);
    bit hs;
    #1;
    w = (!m_valid || out_ready) ? pick() : -1;
    chk({tag, "_gnt"}, gnt, (w < 0) ? 32'd0 : (32'd1 << w));
    @(posedge clk);
    hs = m_valid && out_ready;
    if (hs) m_cnt = (m_cnt + 1) % 65536;
    if (w >= 0) begin
      m_y = dat[w];
      m_sel = w;
      m_valid = 1;
      if (lk[w]) begin
        m_locked = 1;
        m_owner = w;
      end else begin
        m_locked = 0;
        m_ptr = (w + 1) % 8;
      end
    end else begin
      if (hs) m_valid = 0;
      if (m_locked && !req[m_owner]) begin
        m_locked = 0;
        m_ptr = (m_owner + 1) % 8;
      end
    end
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    chk({tag, "_rst_gnt"}, gnt, 0);
    check_regs({tag, "_rst"});
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int w;
    int s;
    model_reset();
    for (int i = 0; i < 8; i++) dat[i] = 16'($urandom);

    // All requesting from reset: strict rotation a..h then a.
    req = 8'hFF;
    out_ready = 1'b1;
    #2;
    do_reset("t1");
    for (int k = 0; k < 9; k++) begin
      step("t1", w);
      chk("t1_rr_sel", sel, k % 8);
      chk("t1_rr_y", y, dat[k % 8]);
    end

    // Two requesters alternate; count four handshakes.
    do_reset("t2");
    req = 8'b0010_0100;
    for (int k = 0; k < 5; k++) begin
      step("t2", w);
      chk("t2_sel", sel, (k % 2 == 0) ? 2 : 5);
    end
    chk("t2_cnt4", xfer_count, 4);

    // Backpressure holds the word and blocks grants; release grants the next in line.
    req = 8'hFF;
    step("t3_load", w);
    s = m_sel;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) step("t3_hold", w);
    out_ready = 1'b1;
    step("t3_rel", w);
    chk("t3_next_sel", sel, (s + 1) % 8);

    // Lone requester d, then drain.
    dat[3] = 16'hBEEF;
    req = 8'h08;
    step("t4", w);
    chk("t4_y", y, 16'hBEEF);
    chk("t4_sel", sel, 3);
    req = 8'h00;
    step("t4_drain", w);
    chk("t4_empty", out_valid, 0);

    // Reset while a word is held and a grant is active.
    req = 8'hFF;
    step("t5_pre", w);
    step("t5_pre2", w);
    do_reset("t5");
    req = 8'h80;
    step("t5", w);
    chk("t5_sel_h", sel, 7);

`ifdef RR_ARB_BURST_LOCK_EN
    do_reset("t6");
    req = 8'h03;
    lk = 8'h01;
    for (int k = 0; k < 3; k++) begin
      step("t6_lock", w);
      chk("t6_lock_sel", sel, 0);
    end
    lk = 8'h00;
    step("t6_unlock", w);
    chk("t6_unlock_sel", sel, 0);
    step("t6_next", w);
    chk("t6_next_sel", sel, 1);
`endif

    // Randomized requesters: hold req and data until granted, then maybe re-request.
    do_reset("rnd");
    req = 8'h00;
    lk = 8'h00;
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      step("rnd", w);
      for (int i = 0; i < 8; i++) begin
        if (i == w || !req[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          if (req[i]) dat[i] = 16'($urandom);
`ifdef RR_ARB_BURST_LOCK_EN
          lk[i] = ($urandom_range(0, 3) == 0);
`endif
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8x16.md
Name: rr_arbiter8x16

Overview:
- Round-robin arbiter that shares one 16-bit output channel between eight requesters (a..h).
- It arbitrates, captures the winner's word into an output register, and drives the matching 3-bit select index downstream.
- This is the sequencing block in front of the 8-way 16-bit mux datapath, with valid/ready handshakes on both sides.
- Throughput: 1 word/cycle when the sink is always ready.

Parameters:
- WIDTH, 16, data width per requester and output.
- CNT_W, 16, width of the transfer counter (wraps).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request per source; bit0 = a ... bit7 = h.
- a,b,c,d,e,f,g,h  input  WIDTH each  source data; must be stable while the matching req bit is high.
- gnt  output  8  one-hot grant (Mealy). Word i transfers at a rising edge where req[i] & gnt[i].
- y  output  WIDTH  registered output word.
- out_valid  output  1  y holds a valid word.
- out_ready  input  1  sink accepts y at an edge where out_valid & out_ready.
- sel  output  3  index (0..7) of the source whose word is in y.
- xfer_count  output  CNT_W  number of output handshakes completed; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate): y=0, out_valid=0, sel=0, ptr=0, xfer_count=0. gnt is forced to 0 while reset is high.
- Internal state: ptr (3 bits) = highest-priority index for the next arbitration. Output register state: EMPTY (out_valid=0) or FULL (out_valid=1).
- Load condition: load = (!out_valid | out_ready) & (|req).
- Winner: first set bit of req scanning ptr, ptr+1, ..., ptr+7 (mod 8).
- On load:
  - gnt = onehot(winner); otherwise gnt = 0.
  - Next edge: y = data of winner, sel = winner, out_valid=1, ptr = (winner+1) mod 8.
- On out_valid & out_ready & !(|req): next out_valid=0. y and sel hold their last values.
- On out_valid & !out_ready: y, sel, out_valid hold and gnt=0 (backpressure). Requesters keep req and data stable.
- Back-to-back: with out_ready=1 continuously, one new word loads each cycle. No bubble.
- xfer_count increments by 1 at each edge with out_valid & out_ready. It wraps 0xFFFF -> 0x0000 at CNT_W=16.
- Single requester: it is granted every load cycle regardless of ptr.
- No requests: ptr unchanged and gnt=0.
- Latency: a word granted at edge N appears on y with out_valid=1 after edge N (one cycle).
- A req change in the same cycle as a grant only affects the next arbitration. gnt is a function of the current req, ptr, out_valid and out_ready only.
- Reset asserted mid-stream: the word in y is dropped and no grant completes in that cycle. After release, arbitration restarts at ptr=0.

Optional Feature:
- Macro: RR_ARB_BURST_LOCK_EN.
- With the macro defined:
  - Adds input port lock (8 bits).
  - If the winner's lock bit is high at its grant, the block enters LOCKED(owner) and ptr is not advanced.
  - While LOCKED, only req[owner] is considered; other requests are ignored.
  - LOCKED exits to normal round-robin at the first grant edge where lock[owner]=0, or on any cycle where req[owner]=0. In both cases ptr = (owner+1) mod 8.
  - Reset clears LOCKED.
- Without the macro: the lock port does not exist and behaviour is pure round-robin as above.

Test Plan:
- Reset with req=8'hFF and out_ready=1 -> gnt=0 during reset. Grants then follow a, b, c, ..., h, a. sel sequence is 0,1,...,7,0 on consecutive cycles; y equals the granted data each cycle.
- req=8'b0010_0100, out_ready=1, starting ptr=0 -> grants alternate c, f, c, f. xfer_count reaches 4 after 4 handshakes.
- One word loaded, out_ready=0 for 5 cycles with req=8'hFF -> y, sel, out_valid stable, gnt=0 throughout. out_ready=1 -> the next requester after the held sel is granted.
- Single request d=16'hBEEF, out_ready=1 -> y=16'hBEEF, sel=3 one cycle after grant. With req dropped, out_valid=0 after the handshake.
- Reset asserted while out_valid=1 and gnt active -> out_valid=0, y=0, xfer_count=0 immediately. After release with req=8'h80, h is granted first.
- (RR_ARB_BURST_LOCK_EN) req=8'h03, lock=8'h01 -> a granted for 3 consecutive cycles. Then lock[0]=0 -> the next grant to a completes, and b is granted next.
